// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing records, presets and width helpers
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam vga_timing_t VGA_800x600 = '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88};

    localparam int RGB_W_DEF = 4;

    typedef struct packed {
        logic [RGB_W_DEF-1:0] r;
        logic [RGB_W_DEF-1:0] g;
        logic [RGB_W_DEF-1:0] b;
    } rgb_t;

    function automatic int total(input vga_timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

    // Never narrower than one bit, so degenerate sizes still give legal vectors
    function automatic int clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping counter with active and sync decode
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int W      = clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    // One extra bit so a region edge equal to 2**W does not truncate to zero
    localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign wrap   = en && (cnt == LAST);
    assign active = {1'b0, cnt} < ACT_END;
    assign sync   = ({1'b0, cnt} >= SYNC_BEG) && ({1'b0, cnt} < SYNC_END);

endmodule

// File: rtl/vga_timing_pipe.sv
// rtl/vga_timing_pipe.sv - VGA timing generator with latency-matched pixel fetch pipeline
// Optional colour-bar generator is built when VGA_TESTPAT_EN is defined.
module vga_timing_pipe
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int READ_LAT = 2,
    parameter int COLOR_W  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [3*COLOR_W-1:0]          pix_rgb,
    input  logic                          test_mode,
    output logic                          req_valid,
    output logic [clog2(H_ACTIVE)-1:0]    req_x,
    output logic [clog2(V_ACTIVE)-1:0]    req_y,
    output logic                          pix_tick,
    output logic                          frame_start,
    output logic                          hs,
    output logic                          vs,
    output logic                          de,
    output logic [COLOR_W-1:0]            r,
    output logic [COLOR_W-1:0]            g,
    output logic [COLOR_W-1:0]            b
);

    localparam vga_timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam vga_timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam int HW = clog2(total(H_T));
    localparam int VW = clog2(total(V_T));
    localparam int XW = clog2(H_ACTIVE);
    localparam int YW = clog2(V_ACTIVE);
    localparam int DW = clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, h_act, h_sync;
    logic          v_wrap_unused, v_act, v_sync;
    logic          req_hs, req_vs;

    // With CLK_DIV=1 div_cnt sits at zero and every clock is a tick
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick     = (div_cnt == DIV_LAST);
    assign pix_tick = tick;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
    ) u_h_axis (
        .clk    (clk),
        .rstn   (rstn),
        .en     (tick),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .active (h_act),
        .sync   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
    ) u_v_axis (
        .clk    (clk),
        .rstn   (rstn),
        .en     (h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap_unused),
        .active (v_act),
        .sync   (v_sync)
    );

    // Request side: snapshot of the counters taken on each tick
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_valid   <= 1'b0;
            req_x       <= '0;
            req_y       <= '0;
            req_hs      <= 1'b0;
            req_vs      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
            if (tick) begin
                req_valid <= h_act && v_act;
                req_x     <= (h_act && v_act) ? h_cnt[XW-1:0] : '0;
                req_y     <= (h_act && v_act) ? v_cnt[YW-1:0] : '0;
                req_hs    <= h_sync;
                req_vs    <= v_sync;
            end
        end
    end

`ifdef VGA_TESTPAT_EN
    localparam int PW = XW + 3;
    logic [PW-1:0] req_word, dly_word;
    assign req_word = {req_x, req_hs, req_vs, req_valid};
`else
    localparam int PW = 3;
    logic [PW-1:0] req_word, dly_word;
    assign req_word = {req_hs, req_vs, req_valid};
`endif

    generate
        if (READ_LAT == 0) begin : g_bypass
            assign dly_word = req_word;
        end else begin : g_pipe
            logic [PW-1:0] stage [READ_LAT];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < READ_LAT; i++) stage[i] <= '0;
                end else if (tick) begin
                    stage[0] <= req_word;
                    for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
                end
            end

            assign dly_word = stage[READ_LAT-1];
        end
    endgenerate

    logic [3*COLOR_W-1:0] src_rgb;

`ifdef VGA_TESTPAT_EN
    logic [XW-1:0] dly_x;
    logic [2:0]    bar_idx;
    logic [2:0]    bar_bits;

    assign dly_x    = dly_word[PW-1:3];
    assign bar_idx  = 3'({dly_x, 3'b000} / (XW+3)'(H_ACTIVE));
    assign bar_bits = ~bar_idx;
    assign src_rgb  = test_mode ? {{COLOR_W{bar_bits[2]}}, {COLOR_W{bar_bits[1]}}, {COLOR_W{bar_bits[0]}}}
                                : pix_rgb;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign src_rgb          = pix_rgb;
`endif

    // Final register: sync polarity applied here, colour forced to zero outside the active area
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hs      <= ~HS_POL;
            vs      <= ~VS_POL;
            de      <= 1'b0;
            {r, g, b} <= '0;
        end else if (tick) begin
            hs      <= dly_word[2] ? HS_POL : ~HS_POL;
            vs      <= dly_word[1] ? VS_POL : ~VS_POL;
            de      <= dly_word[0];
            {r, g, b} <= dly_word[0] ? src_rgb : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb/tb_vga_timing_pipe.sv - randomized self-checking bench for vga_timing_pipe
module tb_vga_timing_pipe;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic tm = 1'b0;
    logic run_chk = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc;

    always #5 clk = ~clk;

    logic [11:0] pat [0:3][0:7];

    logic [11:0] pix_a, pix_b, junk, rd1, rd2;
    logic        rv_a, pt_a, fs_a, hs_a, vs_a, de_a;
    logic        rv_b, pt_b, fs_b, hs_b, vs_b, de_b;
    logic [2:0]  rx_a, rx_b;
    logic [1:0]  ry_a, ry_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    vga_timing_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .READ_LAT(2), .COLOR_W(4)
    ) u_dut (
        .clk(clk), .rstn(rstn), .pix_rgb(pix_a), .test_mode(tm),
        .req_valid(rv_a), .req_x(rx_a), .req_y(ry_a), .pix_tick(pt_a),
        .frame_start(fs_a), .hs(hs_a), .vs(vs_a), .de(de_a),
        .r(r_a), .g(g_a), .b(b_a)
    );

    vga_timing_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .READ_LAT(0), .COLOR_W(4)
    ) u_dut_fast (
        .clk(clk), .rstn(rstn), .pix_rgb(pix_b), .test_mode(tm),
        .req_valid(rv_b), .req_x(rx_b), .req_y(ry_b), .pix_tick(pt_b),
        .frame_start(fs_b), .hs(hs_b), .vs(vs_b), .de(de_b),
        .r(r_b), .g(g_b), .b(b_b)
    );

    // Renderer with a two-tick read latency; garbage is returned for blank requests
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd1 <= '0;
            rd2 <= '0;
        end else if (pt_a) begin
            rd1 <= rv_a ? pat[ry_a][rx_a] : 12'($urandom);
            rd2 <= rd1;
        end
    end
    assign pix_a = rd2;

    always @(posedge clk) junk <= 12'($urandom);
    assign pix_b = rv_b ? pat[ry_b][rx_b] : junk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct packed {
        logic        rv;
        logic [2:0]  rx;
        logic [1:0]  ry;
        logic        pt;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } exp_t;

    function automatic logic [11:0] bar_colour(input int x);
        int bits;
        bits = 7 - x;
        return ((bits & 4) != 0 ? 12'hF00 : 12'h000) |
               ((bits & 2) != 0 ? 12'h0F0 : 12'h000) |
               ((bits & 1) != 0 ? 12'h00F : 12'h000);
    endfunction

    // Screen position p counts pixel ticks from reset release: 16 ticks per line, 8 lines per frame
    function automatic exp_t model(input int c, input int dv, input int lat, input bit bars);
        exp_t e;
        int   t, last, op, h, v;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        t    = c / dv;
        e.pt = (c % dv) == dv - 1;
        if (t > 0) begin
            last = t - 1;
            h = last % 16;
            v = (last / 16) % 8;
            if (h < 8 && v < 4) begin
                e.rv = 1'b1;
                e.rx = 3'(h);
                e.ry = 2'(v);
            end
            e.fs = ((c % dv) == 0) && ((last % 128) == 0);
        end
        op = t - 1 - (lat + 1);
        if (op >= 0) begin
            h = op % 16;
            v = (op / 16) % 8;
            e.hs = !(h >= 10 && h < 13);
            e.vs = !(v >= 5 && v < 7);
            if (h < 8 && v < 4) begin
                e.de  = 1'b1;
                e.rgb = bars ? bar_colour(h) : pat[v][h];
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic randomize_pat();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                pat[y][x] = 12'($urandom);
    endtask

    always @(negedge clk) begin
        exp_t ea, eb;
        bit   bars;
`ifdef VGA_TESTPAT_EN
        bars = tm;
`else
        bars = 1'b0;
`endif
        if (run_chk) begin
            if (!rstn) begin
                check("rst.hs",  32'(hs_a), 32'd1);
                check("rst.vs",  32'(vs_a), 32'd1);
                check("rst.de",  32'(de_a), 32'd0);
                check("rst.rgb", 32'({r_a, g_a, b_a}), 32'd0);
                check("rst.rv",  32'(rv_a), 32'd0);
                check("rst.pt",  32'(pt_a), 32'd0);
                check("rst.fs",  32'(fs_a), 32'd0);
                check("rst.fast.de", 32'(de_b), 32'd0);
                check("rst.fast.hs", 32'(hs_b), 32'd1);
                check("rst.fast.fs", 32'(fs_b), 32'd0);
            end else begin
                ea = model(cyc, 2, 2, bars);
                eb = model(cyc, 1, 0, bars);
                check("a.rv",  32'(rv_a), 32'(ea.rv));
                check("a.rx",  32'(rx_a), 32'(ea.rx));
                check("a.ry",  32'(ry_a), 32'(ea.ry));
                check("a.pt",  32'(pt_a), 32'(ea.pt));
                check("a.fs",  32'(fs_a), 32'(ea.fs));
                check("a.hs",  32'(hs_a), 32'(ea.hs));
                check("a.vs",  32'(vs_a), 32'(ea.vs));
                check("a.de",  32'(de_a), 32'(ea.de));
                check("a.rgb", 32'({r_a, g_a, b_a}), 32'(ea.rgb));
                check("b.rv",  32'(rv_b), 32'(eb.rv));
                check("b.rx",  32'(rx_b), 32'(eb.rx));
                check("b.ry",  32'(ry_b), 32'(eb.ry));
                check("b.pt",  32'(pt_b), 32'(eb.pt));
                check("b.fs",  32'(fs_b), 32'(eb.fs));
                check("b.hs",  32'(hs_b), 32'(eb.hs));
                check("b.vs",  32'(vs_b), 32'(eb.vs));
                check("b.de",  32'(de_b), 32'(eb.de));
                check("b.rgb", 32'({r_b, g_b, b_b}), 32'(eb.rgb));
            end
        end
    end

    initial begin
        int n;
        randomize_pat();
        repeat (10) @(negedge clk);
        rstn = 1'b1;

        // Two full frames, then stop on request h=5, v=2 of the third
        repeat (589) @(negedge clk);
        check("pre.rx", 32'(rx_a), 32'd5);
        check("pre.ry", 32'(ry_a), 32'd2);
        check("pre.de", 32'(de_a), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async.de",  32'(de_a), 32'd0);
        check("async.hs",  32'(hs_a), 32'd1);
        check("async.rgb", 32'({r_a, g_a, b_a}), 32'd0);
        check("async.rv",  32'(rv_a), 32'd0);
        check("async.rx",  32'(rx_a), 32'd0);
        check("async.fast.de", 32'(de_b), 32'd0);

        repeat ($urandom_range(2, 6)) @(negedge clk);
        tm = 1'b1;
        randomize_pat();
        rstn = 1'b1;
        n = 0;
        while (!fs_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fs.first", 32'(n), 32'd2);
        repeat (398) @(negedge clk);

        rstn = 1'b0;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        tm = 1'b0;
        randomize_pat();
        rstn = 1'b1;
        repeat (300) @(negedge clk);

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
